maxpool_seq_ctrl: RTL

- Sequencer for 2x2/stride-2 signed max pooling over one conv feature map held in the conv result buffer (synchronous RAM, 1-cycle read latency).
- Walks every pooling window, fetches its 4 samples over a single read port, reduces them to a signed maximum, and writes one result per window into the pooled-map buffer.
- Sits between the conv engine (which pulses start when a map is complete) and the dense/flatten stage (which consumes the done pulse).

---
 rtl/cnn_pkg.sv | 16 +
 rtl/pool_max_acc.sv | 34 +++
 rtl/maxpool_seq_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and the pooling sequencer state encoding.
// The optional MAXPOOL_SEQ_RELU_EN build clamps pooled outputs (see pool_max_acc).
package cnn_pkg;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 10;
  localparam int IN_ROWS = 26;
  localparam int IN_COLS = 26;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4
  } state_t;
endpackage

// File: rtl/pool_max_acc.sv
// Running signed-maximum register for one pooling window.
// With MAXPOOL_SEQ_RELU_EN defined, a negative maximum is presented as zero.
module pool_max_acc
  import cnn_pkg::*;
#(
  parameter int DATA_W = cnn_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              init,
  input  logic              upd,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] max_val
);
  logic signed [DATA_W-1:0] acc;

  // Strictly-greater update: ties keep the sample that arrived first.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (init) begin
      acc <= din;
    end else if (upd && ($signed(din) > acc)) begin
      acc <= din;
    end
  end

`ifdef MAXPOOL_SEQ_RELU_EN
  assign max_val = acc[DATA_W-1] ? '0 : acc;
`else
  assign max_val = acc;
`endif
endmodule

// File: rtl/maxpool_seq_ctrl.sv
// 2x2/stride-2 signed max-pool sequencer: 4 reads, capture, 1 write per window.
// Handshake: start is a one-cycle pulse accepted only in IDLE; busy spans accept..FIN;
// done pulses once after the final write. MAXPOOL_SEQ_RELU_EN enables output clamping.
module maxpool_seq_ctrl
  import cnn_pkg::*;
#(
  parameter int ADDR_W  = cnn_pkg::ADDR_W,
  parameter int DATA_W  = cnn_pkg::DATA_W,
  parameter int IN_ROWS = cnn_pkg::IN_ROWS,
  parameter int IN_COLS = cnn_pkg::IN_COLS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);
  localparam int OUT_ROWS = IN_ROWS / 2;
  localparam int OUT_COLS = IN_COLS / 2;

  state_t            state;
  logic [1:0]        k;
  logic [ADDR_W-1:0] r, c, in_base_q, out_base_q;
  logic [ADDR_W-1:0] nxt_r, nxt_c;
  logic              last_col, last_row;
  logic              acc_clr, acc_init, acc_upd;

  assign last_col = (c == ADDR_W'(OUT_COLS - 1));
  assign last_row = (r == ADDR_W'(OUT_ROWS - 1));
  assign nxt_c    = last_col ? '0 : c + ADDR_W'(1);
  assign nxt_r    = last_col ? r + ADDR_W'(1) : r;

  // k[1] selects the lower row, k[0] the right column: TL, TR, BL, BR.
  function automatic logic [ADDR_W-1:0] win_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [ADDR_W-1:0] rr,
                                                 input logic [ADDR_W-1:0] cc,
                                                 input logic [1:0]        kk);
    logic [ADDR_W-1:0] row, col;
    row = (rr << 1) | ADDR_W'(kk[1]);
    col = (cc << 1) | ADDR_W'(kk[0]);
    return base + row * ADDR_W'(IN_COLS) + col;
  endfunction

  // Read k-1 data lands during RD cycle k; read 3 lands during CAP.
  assign acc_clr  = (state == IDLE) && start;
  assign acc_init = (state == RD) && (k == 2'd1);
  assign acc_upd  = ((state == RD) && k[1]) || (state == CAP);

  pool_max_acc #(.DATA_W(DATA_W)) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clr     (acc_clr),
    .init    (acc_init),
    .upd     (acc_upd),
    .din     (rd_data),
    .max_val (wr_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      r          <= '0;
      c          <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            in_base_q  <= in_base;
            out_base_q <= out_base;
            r          <= '0;
            c          <= '0;
            k          <= '0;
            busy       <= 1'b1;
            rd_en      <= 1'b1;
            rd_addr    <= in_base;
            state      <= RD;
          end
        end
        RD: begin
          k <= k + 2'd1;
          if (k == 2'd3) begin
            rd_en <= 1'b0;
            state <= CAP;
          end else begin
            rd_addr <= win_addr(in_base_q, r, c, k + 2'd1);
          end
        end
        CAP: begin
          wr_en   <= 1'b1;
          wr_addr <= out_base_q + r * ADDR_W'(OUT_COLS) + c;
          state   <= WR;
        end
        WR: begin
          wr_en <= 1'b0;
          r     <= nxt_r;
          c     <= nxt_c;
          if (last_col && last_row) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            k       <= '0;
            rd_en   <= 1'b1;
            rd_addr <= win_addr(in_base_q, nxt_r, nxt_c, 2'd0);
            state   <= RD;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
